// File: rtl/branch_update_queue.sv
// Branch update queue: holds predicted branches until resolved and committed in order.
// Optional BUQ_STATS_EN adds saturating commit / mispredict counters.
`ifndef PRED_TABLE_BIT
`define PRED_TABLE_BIT 10
`endif

module branch_update_queue #(
  parameter int DEPTH_BIT = 3,
  parameter int IDX_W     = `PRED_TABLE_BIT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 enq_valid,
  input  logic                 enq_pred,
  input  logic [IDX_W-1:0]     enq_g_ind,
  input  logic [IDX_W-1:0]     enq_l_ind,
  output logic                 enq_ready,
  output logic [DEPTH_BIT-1:0] enq_tag,
  input  logic                 res_valid,
  input  logic [DEPTH_BIT-1:0] res_tag,
  input  logic                 res_taken,
  input  logic                 cmt_valid,
  output logic                 cmt_ready,
  input  logic                 flush_in,
  output logic                 br_req,
  output logic                 br_correct,
  output logic [31:0]          br_res,
  output logic [IDX_W-1:0]     br_g_ind,
  output logic [IDX_W-1:0]     br_l_ind,
  output logic [DEPTH_BIT:0]   count_out,
  output logic [31:0]          stat_commits,
  output logic [31:0]          stat_mispred
);

  localparam int N = 1 << DEPTH_BIT;

  logic [N-1:0]           valid_q, valid_d;
  logic [N-1:0]           rsv_q, rsv_d;
  logic [N-1:0]           pred_q, pred_d;
  logic [N-1:0]           act_q, act_d;
  logic [IDX_W-1:0]       g_q [N];
  logic [IDX_W-1:0]       g_d [N];
  logic [IDX_W-1:0]       l_q [N];
  logic [IDX_W-1:0]       l_d [N];
  logic [DEPTH_BIT-1:0]   head_q, head_d;
  logic [DEPTH_BIT-1:0]   tail_q, tail_d;
  logic [DEPTH_BIT:0]     count_q, count_d;
  logic                   br_req_q, br_req_d;
  logic                   br_cor_q, br_cor_d;
  logic [31:0]            br_res_q, br_res_d;
  logic [IDX_W-1:0]       br_g_q, br_g_d;
  logic [IDX_W-1:0]       br_l_q, br_l_d;

  logic enq_go, res_go, cmt_go;

  // count never exceeds N, so its MSB alone flags full
  assign enq_ready = ~count_q[DEPTH_BIT];
  assign enq_tag   = tail_q;
  assign cmt_ready = valid_q[head_q] & rsv_q[head_q];
  assign count_out = count_q;

  assign br_req     = br_req_q;
  assign br_correct = br_cor_q;
  assign br_res     = br_res_q;
  assign br_g_ind   = br_g_q;
  assign br_l_ind   = br_l_q;

  assign enq_go = rdy_in & enq_valid & enq_ready & ~flush_in;
  assign res_go = rdy_in & res_valid & valid_q[res_tag] & ~flush_in;
  assign cmt_go = rdy_in & cmt_valid & cmt_ready;

  always_comb begin
    valid_d  = valid_q;
    rsv_d    = rsv_q;
    pred_d   = pred_q;
    act_d    = act_q;
    g_d      = g_q;
    l_d      = l_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    br_req_d = br_req_q;
    br_cor_d = br_cor_q;
    br_res_d = br_res_q;
    br_g_d   = br_g_q;
    br_l_d   = br_l_q;
    if (rdy_in) begin
      br_req_d = cmt_go;
      if (res_go) begin
        rsv_d[res_tag] = 1'b1;
        act_d[res_tag] = res_taken;
      end
      if (enq_go) begin
        valid_d[tail_q] = 1'b1;
        rsv_d[tail_q]   = 1'b0;
        pred_d[tail_q]  = enq_pred;
        g_d[tail_q]     = enq_g_ind;
        l_d[tail_q]     = enq_l_ind;
        tail_d          = tail_q + DEPTH_BIT'(1);
      end
      // commit wins over a stale resolve aimed at the head slot
      if (cmt_go) begin
        valid_d[head_q] = 1'b0;
        rsv_d[head_q]   = 1'b0;
        head_d          = head_q + DEPTH_BIT'(1);
        br_cor_d        = act_q[head_q] == pred_q[head_q];
        br_res_d        = {31'b0, act_q[head_q]};
        br_g_d          = g_q[head_q];
        br_l_d          = l_q[head_q];
      end
      count_d = count_q + (DEPTH_BIT+1)'(enq_go)
                        - (DEPTH_BIT+1)'(cmt_go);
      if (flush_in) begin
        valid_d = '0;
        rsv_d   = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q  <= '0;
      rsv_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      br_req_q <= 1'b0;
      br_cor_q <= 1'b0;
      br_res_q <= '0;
      br_g_q   <= '0;
      br_l_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      rsv_q    <= rsv_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      br_req_q <= br_req_d;
      br_cor_q <= br_cor_d;
      br_res_q <= br_res_d;
      br_g_q   <= br_g_d;
      br_l_q   <= br_l_d;
    end
  end

  // payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk_in) begin
    pred_q <= pred_d;
    act_q  <= act_d;
    g_q    <= g_d;
    l_q    <= l_d;
  end

`ifdef BUQ_STATS_EN
  logic [31:0] sc_q, sc_d;
  logic [31:0] sm_q, sm_d;
  logic        mis;

  assign mis = act_q[head_q] != pred_q[head_q];

  always_comb begin
    sc_d = sc_q;
    sm_d = sm_q;
    if (cmt_go) begin
      if (sc_q != '1) sc_d = sc_q + 32'd1;
      if (mis && sm_q != '1) sm_d = sm_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sc_q <= '0;
      sm_q <= '0;
    end else begin
      sc_q <= sc_d;
      sm_q <= sm_d;
    end
  end

  assign stat_commits = sc_q;
  assign stat_mispred = sm_q;
`else
  assign stat_commits = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Random + directed bench for branch_update_queue against a queue-based model.
// Stats checks follow BUQ_STATS_EN.
`ifndef PRED_TABLE_BIT
`define PRED_TABLE_BIT 10
`endif

module tb_branch_update_queue;

  localparam int IW = `PRED_TABLE_BIT;
  localparam int DB = 3;
  localparam int N  = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          rdy_in;
  logic          enq_valid;
  logic          enq_pred;
  logic [IW-1:0] enq_g_ind;
  logic [IW-1:0] enq_l_ind;
  logic          enq_ready;
  logic [DB-1:0] enq_tag;
  logic          res_valid;
  logic [DB-1:0] res_tag;
  logic          res_taken;
  logic          cmt_valid;
  logic          cmt_ready;
  logic          flush_in;
  logic          br_req;
  logic          br_correct;
  logic [31:0]   br_res;
  logic [IW-1:0] br_g_ind;
  logic [IW-1:0] br_l_ind;
  logic [DB:0]   count_out;
  logic [31:0]   stat_commits;
  logic [31:0]   stat_mispred;

  branch_update_queue dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .enq_valid(enq_valid), .enq_pred(enq_pred),
    .enq_g_ind(enq_g_ind), .enq_l_ind(enq_l_ind),
    .enq_ready(enq_ready), .enq_tag(enq_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .flush_in(flush_in),
    .br_req(br_req), .br_correct(br_correct), .br_res(br_res),
    .br_g_ind(br_g_ind), .br_l_ind(br_l_ind), .count_out(count_out),
    .stat_commits(stat_commits), .stat_mispred(stat_mispred)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int tag;
    bit pred;
    bit act;
    bit rsv;
    int g;
    int l;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  bit   e_req, e_cor;
  int   e_res, e_g, e_l;
  int   e_sc, e_sm;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void chk(string nm, longint a, longint e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_tail = 0;
    e_req  = 0;
    e_sc   = 0;
    e_sm   = 0;
  endfunction

  // one rising edge of the reference behaviour, from the inputs now applied
  function automatic void model_step();
    int  pre;
    int  ridx;
    bit  cmt;
    if (!rst_n_in) begin
      model_clear();
      return;
    end
    if (!rdy_in) return;
    pre  = mq.size();
    cmt  = cmt_valid && pre > 0 && mq[0].rsv;
    ridx = -1;
    if (res_valid)
      foreach (mq[i]) if (mq[i].tag == int'(res_tag)) ridx = i;
    e_req = cmt;
    if (cmt) begin
      e_cor = mq[0].act == mq[0].pred;
      e_res = int'(mq[0].act);
      e_g   = mq[0].g;
      e_l   = mq[0].l;
`ifdef BUQ_STATS_EN
      e_sc++;
      if (!e_cor) e_sm++;
`endif
      void'(mq.pop_front());
      ridx--;
    end
    if (flush_in) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (ridx >= 0) begin
        mq[ridx].rsv = 1;
        mq[ridx].act = res_taken;
      end
      if (enq_valid && pre < N) begin
        mq.push_back('{m_tail, enq_pred, 1'b0, 1'b0,
                       int'(enq_g_ind), int'(enq_l_ind)});
        m_tail = (m_tail + 1) % N;
      end
    end
  endfunction

  task automatic check_all();
    chk("count_out", count_out, mq.size());
    chk("enq_ready", enq_ready, mq.size() < N);
    chk("enq_tag", enq_tag, m_tail);
    chk("cmt_ready", cmt_ready, mq.size() > 0 && mq[0].rsv);
    chk("br_req", br_req, e_req);
    if (e_req) begin
      chk("br_correct", br_correct, e_cor);
      chk("br_res", br_res, e_res);
      chk("br_g_ind", br_g_ind, e_g);
      chk("br_l_ind", br_l_ind, e_l);
    end
    chk("stat_commits", stat_commits, e_sc);
    chk("stat_mispred", stat_mispred, e_sm);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic idle();
    enq_valid = 0;
    res_valid = 0;
    cmt_valid = 0;
    flush_in  = 0;
    rdy_in    = 1;
  endtask

  task automatic enq(bit p, int g, int l);
    idle();
    enq_valid = 1;
    enq_pred  = p;
    enq_g_ind = IW'(g);
    enq_l_ind = IW'(l);
    cycle();
    idle();
  endtask

  task automatic resolve(int t, bit tk);
    idle();
    res_valid = 1;
    res_tag   = DB'(t);
    res_taken = tk;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    rst_n_in = 0;
    #1;
    chk("async_rst_count", count_out, 0);
    chk("async_rst_br_req", br_req, 0);
    model_clear();
    @(negedge clk_in);
    check_all();
    rst_n_in = 1;
  endtask

  initial begin
    rst_n_in  = 1;
    enq_pred  = 0;
    enq_g_ind = '0;
    enq_l_ind = '0;
    res_tag   = '0;
    res_taken = 0;
    idle();
    model_clear();
    @(negedge clk_in);
    do_reset();
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_cmt_ready", cmt_ready, 0);
    chk("rst_enq_tag", enq_tag, 0);

    // basic enqueue / resolve / commit
    enq(1, 5, 9);
    resolve(0, 1);
    chk("t30_cmt_ready", cmt_ready, 1);
    cmt_valid = 1;
    cycle();
    idle();
    chk("t30_br_req", br_req, 1);
    chk("t30_br_correct", br_correct, 1);
    chk("t30_br_res", br_res, 1);
    chk("t30_br_g", br_g_ind, 5);
    chk("t30_br_l", br_l_ind, 9);
    cycle();
    chk("t30_br_req_drop", br_req, 0);

    // fill to full, drop the ninth, one commit frees a slot
    for (int i = 0; i < N; i++) enq(0, i, i + 1);
    chk("t31_count_full", count_out, 8);
    chk("t31_enq_ready", enq_ready, 0);
    enq(1, 3, 3);
    chk("t31_count_drop", count_out, 8);
    resolve(1, 0);
    cmt_valid = 1;
    cycle();
    idle();
    chk("t31_enq_ready_back", enq_ready, 1);
    chk("t31_count_7", count_out, 7);
    flush_in = 1;
    cycle();
    idle();
    chk("flush_count", count_out, 0);

    // out-of-order resolves, in-order mispredicted commits
    for (int i = 0; i < 3; i++) enq(1, 20 + i, 30 + i);
    resolve(2, 0);
    resolve(1, 0);
    resolve(0, 0);
    cmt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t32_br_req", br_req, 1);
      chk("t32_br_correct", br_correct, 0);
      chk("t32_br_res", br_res, 0);
      chk("t32_br_g", br_g_ind, 20 + i);
    end
    idle();
    cycle();

    // commit + flush together
    for (int i = 0; i < 4; i++) enq(0, i, i);
    resolve(3, 1);
    cmt_valid = 1;
    flush_in  = 1;
    cycle();
    idle();
    chk("t33_br_req", br_req, 1);
    chk("t33_br_correct", br_correct, 0);
    chk("t33_count", count_out, 0);
    chk("t33_cmt_ready", cmt_ready, 0);
    cycle();
    chk("t33_br_req_drop", br_req, 0);

    // stall right after a commit
    enq(1, 7, 8);
    resolve(0, 1);
    cmt_valid = 1;
    cycle();
    idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t34_br_req_held", br_req, 1);
    end
    rdy_in = 1;
    cycle();
    chk("t34_br_req_drop", br_req, 0);

`ifdef BUQ_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      int t;
      t = m_tail;
      enq(1, i, i);
      resolve(t, i >= 3);
      cmt_valid = 1;
      cycle();
      idle();
    end
    chk("t35_commits", stat_commits, 10);
    chk("t35_mispred", stat_mispred, 3);
    do_reset();
    chk("t35_commits_rst", stat_commits, 0);
    chk("t35_mispred_rst", stat_mispred, 0);
`else
    chk("stats_tied_commits", stat_commits, 0);
    chk("stats_tied_mispred", stat_mispred, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rdy_in    = $urandom_range(0, 7) != 0;
      enq_valid = $urandom_range(0, 2) != 0;
      enq_pred  = $urandom_range(0, 1) != 0;
      enq_g_ind = IW'($urandom);
      enq_l_ind = IW'($urandom);
      res_valid = $urandom_range(0, 9) < 7;
      res_tag   = DB'($urandom_range(0, N - 1));
      res_taken = $urandom_range(0, 1) != 0;
      cmt_valid = $urandom_range(0, 1) != 0;
      flush_in  = $urandom_range(0, 59) == 0;
      if (i % 1000 == 999) begin
        #3;
        do_reset();
      end else begin
        cycle();
      end
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
